// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared types and helpers for the AVMM-LVDS bridge.
// Header packing, lane width check and framer FSM states.
package avmm_lvds_bridge_pkg;

   localparam int HDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA
   } state_t;

   function automatic bit lane_w_ok(input int w);
      return (w == 1) || (w == 2) || (w == 4) ||
             (w == 8) || (w == 16) || (w == 32);
   endfunction

   // tr | burst | address | burstcnt_byteena, MSB to LSB
   function automatic logic [HDR_W-1:0] pack_hdr(
      input logic             tr,
      input logic             burst,
      input logic [HDR_W-1:0] addr,
      input logic [HDR_W-1:0] field,
      input int               bcw
   );
      logic [HDR_W-1:0] fmask;
      logic [HDR_W-1:0] amask;
      fmask = (32'h1 << bcw) - 32'h1;
      amask = (32'h1 << (30 - bcw)) - 32'h1;
      return {tr, burst, 30'h0}
           | ((addr & amask) << bcw)
           | (field & fmask);
   endfunction

endpackage

// File: rtl/avmm_lvds_lane_ser.sv
// 32-bit word to LANE_W beat serializer, MSB first.
// Holds its beat while valid and not ready.
module avmm_lvds_lane_ser
   import avmm_lvds_bridge_pkg::*;
#(
   parameter int LANE_W = 8,
   parameter int BEATS  = 32 / LANE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [HDR_W-1:0]  word,
   input  logic              ready,
   output logic [LANE_W-1:0] data,
   output logic              valid,
   output logic              first_beat,
   output logic              last_beat
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [HDR_W-1:0] sh_q;
   logic [HDR_W-1:0] sh_nxt;
   logic [CNT_W-1:0] cnt_q;

   if (BEATS > 1) begin : g_shift
      assign sh_nxt = {sh_q[HDR_W-1-LANE_W:0],
                       {LANE_W{1'b0}}};
   end else begin : g_noshift
      assign sh_nxt = sh_q;
   end

   assign data       = sh_q[HDR_W-1 -: LANE_W];
   assign first_beat = (cnt_q == '0);
   assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q  <= '0;
         cnt_q <= '0;
         valid <= 1'b0;
      end else if (load) begin
         sh_q  <= word;
         cnt_q <= '0;
         valid <= 1'b1;
      end else if (valid && ready) begin
         if (last_beat) begin
            valid <= 1'b0;
         end else begin
            sh_q  <= sh_nxt;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/avmm_lvds_req_framer.sv
// Request-side framer: Avalon-MM slave to LVDS lane beats.
// One frame per command: header word, then write data words.
module avmm_lvds_req_framer
   import avmm_lvds_bridge_pkg::*;
#(
   parameter  int BURSTCNT_W = 11,
   parameter  int LANE_W     = 8,
   localparam int ADDR_W     = 32 - 2 - BURSTCNT_W,
   localparam int BEATS      = 32 / LANE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [31:0]           avs_writedata,
   input  logic [3:0]            avs_byteenable,
   input  logic [BURSTCNT_W-1:0] avs_burstcount,
   output logic                  avs_waitrequest,
   output logic [LANE_W-1:0]     tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_sop,
   output logic                  tx_eop,
   output logic                  busy,
   output logic                  err_burst0
);

   if (!lane_w_ok(LANE_W)) begin : g_bad_lane
      $error("avmm_lvds_req_framer: illegal LANE_W");
   end

   state_t state_q;
   state_t state_d;

   logic                  tr_q;
   logic [BURSTCNT_W-1:0] rem_q;
   logic                  start;
   logic                  bc_zero;
   logic [BURSTCNT_W-1:0] eff_bc;
   logic                  burst;
   logic [BURSTCNT_W-1:0] field;
   logic [HDR_W-1:0]      hdr_word;

   logic             ser_load;
   logic [HDR_W-1:0] ser_word;
   logic             ser_first;
   logic             ser_last;
   logic             fire;
   logic             data_acc;

   assign start   = avs_read || avs_write;
   assign bc_zero = (avs_burstcount == '0);
   assign eff_bc  = bc_zero ? BURSTCNT_W'(1)
                            : avs_burstcount;
   assign burst   = (eff_bc > BURSTCNT_W'(1));
   assign field   = burst ? eff_bc
                          : BURSTCNT_W'(avs_byteenable);

   // Read wins when both strobes are high.
   assign hdr_word = pack_hdr(avs_read, burst,
                              HDR_W'(avs_address),
                              HDR_W'(field),
                              BURSTCNT_W);

   assign fire = tx_valid && tx_ready;
   assign busy = (state_q != IDLE);

   avmm_lvds_lane_ser #(
      .LANE_W (LANE_W),
      .BEATS  (BEATS)
   ) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ser_load),
      .word       (ser_word),
      .ready      (tx_ready),
      .data       (tx_data),
      .valid      (tx_valid),
      .first_beat (ser_first),
      .last_beat  (ser_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = HDR;
         HDR: begin
            if (fire && ser_last)
               state_d = tr_q ? IDLE : DATA;
         end
         DATA: begin
            if (fire && ser_last && rem_q == '0)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ser_load        = 1'b0;
      ser_word        = hdr_word;
      avs_waitrequest = 1'b1;
      data_acc        = 1'b0;
      tx_sop          = 1'b0;
      tx_eop          = 1'b0;
      unique case (state_q)
         IDLE: ser_load = start;
         HDR: begin
            tx_sop   = tx_valid && ser_first;
            tx_eop   = tx_valid && ser_last && tr_q;
            ser_word = avs_writedata;
            if (fire && ser_last) begin
               avs_waitrequest = 1'b0;
               ser_load        = !tr_q;
            end
         end
         DATA: begin
            tx_eop   = tx_valid && ser_last &&
                       (rem_q == '0);
            ser_word = avs_writedata;
            // Next word may arrive late: lane idles until it does.
            if (rem_q != '0 && avs_write &&
                (!tx_valid || (fire && ser_last))) begin
               data_acc        = 1'b1;
               avs_waitrequest = 1'b0;
               ser_load        = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tr_q       <= 1'b0;
         rem_q      <= '0;
         err_burst0 <= 1'b0;
      end else begin
         if (state_q == IDLE && start) begin
            tr_q  <= avs_read;
            rem_q <= eff_bc - BURSTCNT_W'(1);
            if (bc_zero) err_burst0 <= 1'b1;
         end else if (data_acc) begin
            rem_q <= rem_q - BURSTCNT_W'(1);
         end
      end
   end

endmodule

// File: doc/avmm_lvds_req_framer.md
Name: avmm_lvds_req_framer

Overview:
- Request-side framer of the AVMM-LVDS bridge: Avalon-MM slave in, serial lane word stream out, feeding the LVDS serializer.
- Each accepted transaction becomes one frame: a 32-bit request header, then write data words for writes only. Every 32-bit word is sliced into LANE_W-bit beats, MSB first.
- Parametrised successor of the fixed 32-bit header format: adds configurable lane width and burst field width, frame delimiting (sop/eop), and an illegal-burstcount flag.

Parameters:
- BURSTCNT_W, 11: width of avs_burstcount and of the header burstcnt_byteena field.
- ADDR_W, 32-2-BURSTCNT_W: word-address width (derived; not overridable).
- LANE_W, 8: output beat width. Legal values are 1, 2, 4, 8, 16, 32; anything else fails elaboration.
- BEATS, 32/LANE_W: beats per 32-bit word (derived).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- avs_address  in  ADDR_W  word address.
- avs_read  in  1  read request.
- avs_write  in  1  write request/beat.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  byte enables (used only for non-burst transactions).
- avs_burstcount  in  BURSTCNT_W  burst length in words.
- avs_waitrequest  out  1  Avalon backpressure.
- tx_data  out  LANE_W  lane beat.
- tx_valid  out  1  beat valid.
- tx_ready  in  1  downstream accepts the beat.
- tx_sop  out  1  first header beat.
- tx_eop  out  1  last beat of the frame.
- busy  out  1  state != IDLE.
- err_burst0  out  1  sticky: a burstcount of 0 was received.

Behaviour:
- Reset (async, rst_n=0): avs_waitrequest=1, tx_valid=0, tx_sop=0, tx_eop=0, busy=0, err_burst0=0, FSM=IDLE, counters cleared.
- avs_waitrequest is 1 except during the single accept cycles defined below.
- Header layout, MSB to LSB: tr(1: 0=WRITE, 1=READ), burst(1), address(ADDR_W), burstcnt_byteena(BURSTCNT_W).
  - burst=1 iff effective burstcount > 1; the field then holds the burstcount.
  - Otherwise the field holds avs_byteenable zero-extended.
- Effective burstcount: a burstcount of 0 is treated as 1 and sets err_burst0 (cleared only by reset).
- If avs_read and avs_write are both high, the read wins and the write stays pending.
- Handshake: a beat transfers when tx_valid && tx_ready. tx_data, tx_valid, tx_sop and tx_eop are held stable while tx_valid && !tx_ready.
- FSM states:
  - IDLE: on avs_read or avs_write, latch the header fields (avs_waitrequest stays 1) -> HDR the next cycle, with tx_valid=1 and tx_sop=1 on beat 0.
  - HDR: emit BEATS header beats. On the transfer of the last header beat, drive avs_waitrequest=0 for that cycle (the command is accepted).
    - Read: tx_eop=1 on the last header beat; -> IDLE.
    - Write: capture avs_writedata in the same accept cycle and load remaining=burst-1; -> DATA.
  - DATA: emit BEATS beats of the captured word.
    - On the last beat, if remaining>0: drive avs_waitrequest=0, capture the next avs_writedata (avs_write must be high, otherwise wait in DATA with tx_valid=0), decrement remaining.
    - When remaining==0: tx_eop=1 on the last beat; -> IDLE.
- Throughput: with tx_ready held at 1, beats are back-to-back with no bubble between header and data or between data words. A frame occupies BEATS*(1+N) cycles for an N-word write, or BEATS cycles for a read.
- Latency: avs_read/avs_write -> first tx_valid is 1 cycle.
- LANE_W=32: BEATS=1, so tx_sop and tx_eop coincide on a read frame.
- Reset mid-frame: the frame is truncated immediately and no eop is emitted. The receiver resynchronises on the next tx_sop.
- Maximum burst is 2**(BURSTCNT_W-1). Larger values are transmitted as-is; the bridge does not check them.

Decomposition:
- Shared package avmm_lvds_bridge_pkg gains:
  - HDR_W=32.
  - Parametrised header-pack function (tr, burst, address, field, BURSTCNT_W -> 32 bits).
  - LANE_W legality check.
  - FSM state enum (IDLE, HDR, DATA).
- Sub-module avmm_lvds_lane_ser: 32-bit load, LANE_W MSB-first shift with valid/ready, beat counter, last_beat flag. Instantiated once and shared by header and data.

Test Plan:
- LANE_W=8, read, address 0x12345, byteenable 0xF, burstcount 1 -> beats 0x89,0x1A,0x28,0x0F; sop on 0x89, eop on 0x0F; one waitrequest=0 cycle on beat 0x0F.
- LANE_W=8, write burst address 0x10, burstcount 4, data 0x11111111..0x44444444 -> header beats 0x40,0x00,0x80,0x04, then 16 data beats with no gaps; eop on the final 0x44; exactly 4 waitrequest=0 cycles.
- Same burst with tx_ready toggling 1,0,1,0 -> outputs held stable while tx_ready=0; identical beat sequence; no beat lost.
- LANE_W=32, single write, address 0, byteenable 0x3, data 0xDEADBEEF -> beats 0x00000003 (sop) then 0xDEADBEEF (eop).
- Burstcount 0 on a read -> frame sent as burst=0 with byteenable field; err_burst0=1 and stays 1 until rst_n=0.
- rst_n pulsed low mid-DATA -> all outputs immediately at reset values; the next read produces a clean frame starting with sop.
